alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 8 to 64).
REQ-002 SHALL have input clock, 1 bit, sole clock; all state updates on its rising edge.
REQ-003 SHALL have input reset, 1 bit, synchronous, active-high.
REQ-004 SHALL have input in_valid, 1 bit, operand/opcode presented.
REQ-005 SHALL have output in_ready, 1 bit, block can accept an operation.
REQ-006 SHALL have inputs x and y, WIDTH bits each, operands.
REQ-007 SHALL have input op, 4 bits, opcode.
REQ-008 SHALL have output out_valid, 1 bit, result and flags valid.
REQ-009 SHALL have input out_ready, 1 bit, consumer takes result.
REQ-010 SHALL have output r, WIDTH bits, result.
REQ-011 SHALL have outputs zero, neg, carry and ovf, 1 bit each, flags for r.
REQ-012 SHALL have output illegal, 1 bit, set when the accepted opcode is unsupported.

Function
REQ-013 SHALL accept an operation on a cycle with in_valid and in_ready both high, registering x, y and op.
REQ-014 SHALL decode opcodes as: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL by y[log2 WIDTH-1:0], 0101 SRL, 0110 SUB, 0111 SLT signed (r = 1 or 0), 1000 MUL low WIDTH bits, 1001 DIVU, 1010 REMU; 1011 to 1111 are illegal.
REQ-015 SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-016 In IDLE, an accepted non-iterative op SHALL go to DONE, with out_valid high on the next cycle (latency 1).
REQ-017 An accepted MUL, DIVU or REMU SHALL go to CALC and run shift-add multiply or restoring divide for exactly WIDTH cycles, then go to DONE (latency WIDTH+1).
REQ-018 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready), allowing back-to-back issue.
REQ-019 In DONE with out_ready low, r, flags, illegal and out_valid SHALL hold stable.
REQ-020 In DONE with out_ready high and no new accept, SHALL return to IDLE and drop out_valid.
REQ-021 Flags: zero = (r==0); neg = r[WIDTH-1].
REQ-022 Flags: carry = carry-out for ADD and NOT borrow for SUB, else 0.
REQ-023 Flags: ovf = signed overflow for ADD/SUB, else 0.
REQ-024 Outputs SHALL never be X; an illegal opcode SHALL give r=0, zero=1, illegal=1, latency 1.
REQ-025 Divide by zero SHALL give DIVU r = all ones and REMU r = x, with no extra latency.
REQ-026 SUB and SLT with x==y SHALL give r=0, zero=1 (SUB carry=1).
REQ-027 in_valid while in CALC SHALL be ignored (in_ready low); operands SHALL not be sampled.

Reset
REQ-028 On reset, state SHALL go to IDLE.
REQ-029 On reset, out_valid, r, zero, neg, carry, ovf and illegal SHALL all clear to 0, and in_ready SHALL be 1 the next cycle.
REQ-030 Reset during CALC SHALL abort the iteration with no result produced; reset SHALL take priority over any simultaneous accept.

Configuration
REQ-031 Macro ALU_MULDIV_EN defined SHALL include the iterative MUL/DIVU/REMU datapath and the CALC state.
REQ-032 Macro ALU_MULDIV_EN undefined SHALL treat opcodes 1000 to 1010 as illegal (REQ-024) and never enter CALC.

Verification
REQ-033 Reset, then ADD x=32'hFFFFFFFF, y=1 -> after 1 cycle r=0, zero=1, carry=1, ovf=0.
REQ-034 SUB x=32'h80000000, y=1 -> r=32'h7FFFFFFF, ovf=1, neg=0.
REQ-035 MUL x=1234, y=5678 -> out_valid exactly 33 cycles after accept, r=7006652; DIVU x=100, y=7 -> r=14; REMU -> r=2.
REQ-036 DIVU x=55, y=0 -> r=32'hFFFFFFFF; REMU x=55, y=0 -> r=55.
REQ-037 ADD result with out_ready low for 5 cycles -> r and out_valid held; then out_ready high with new in_valid -> back-to-back accept, no bubble.
REQ-038 Reset asserted mid-DIVU, op=1111, and ALU_MULDIV_EN undefined with MUL -> respectively IDLE and out_valid=0 next cycle; illegal=1 with r=0; illegal=1.

Source files
------------

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//
// Purpose: ALU with a valid/ready handshake on both sides. Logic, add/sub,
// shift and set-less-than operations take one cycle. MUL, DIVU and REMU are
// iterative: a shift-add multiply or a restoring divide runs for WIDTH cycles.
// After those cycles, one extra cycle moves the FSM to DONE.
//
// Optional feature: define the macro ALU_MULDIV_EN to build the iterative
// MUL/DIVU/REMU datapath and the CALC state. When the macro is not defined,
// opcodes 1000..1010 are treated as illegal.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - synchronous, active-high
//   in_valid   - operands/opcode presented
//   in_ready   - block can accept an operation
//   x, y       - WIDTH-bit operands
//   op         - 4-bit opcode
//   out_valid  - r and flags are valid
//   out_ready  - consumer takes the result
//   r          - WIDTH-bit result
//   zero, neg, carry, ovf - flags for r
//   illegal    - accepted opcode was unsupported
// -----------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
`endif

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] r_reg;
    logic             zero_reg, neg_reg, carry_reg, ovf_reg, illegal_reg;

    logic             accept;
    logic             is_iter;
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [WIDTH-1:0] quick_r;
    logic             quick_carry, quick_ovf, quick_illegal;
    logic             calc_done;
    logic [WIDTH-1:0] calc_result;

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);

    assign r       = r_reg;
    assign zero    = zero_reg;
    assign neg     = neg_reg;
    assign carry   = carry_reg;
    assign ovf     = ovf_reg;
    assign illegal = illegal_reg;

    // Single-cycle result, computed directly from the presented operands.
    // An illegal opcode leaves quick_r at 0, so the zero flag comes out as 1.
    always_comb begin
        sum_ext       = {1'b0, x} + {1'b0, y};
        diff_ext      = {1'b0, x} - {1'b0, y};
        quick_r       = '0;
        quick_carry   = 1'b0;
        quick_ovf     = 1'b0;
        quick_illegal = 1'b0;
        is_iter       = 1'b0;
        case (op)
            OP_AND: quick_r = x & y;
            OP_OR:  quick_r = x | y;
            OP_XOR: quick_r = x ^ y;
            OP_SLL: quick_r = x << y[SHW-1:0];
            OP_SRL: quick_r = x >> y[SHW-1:0];
            OP_ADD: begin
                quick_r     = sum_ext[WIDTH-1:0];
                quick_carry = sum_ext[WIDTH];
                quick_ovf   = (x[WIDTH-1] == y[WIDTH-1]) &&
                              (sum_ext[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                quick_r     = diff_ext[WIDTH-1:0];
                // Carry on subtract is the inverted borrow.
                quick_carry = ~diff_ext[WIDTH];
                quick_ovf   = (x[WIDTH-1] != y[WIDTH-1]) &&
                              (diff_ext[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SLT: quick_r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
`ifdef ALU_MULDIV_EN
            OP_MUL, OP_DIVU, OP_REMU: is_iter = 1'b1;
`endif
            default: quick_illegal = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH);

    // During MUL: acc = partial product, a = multiplier, b = multiplicand.
    // During DIV: acc = partial remainder, a = dividend/quotient, b = divisor.
    logic [WIDTH-1:0] acc_reg, a_reg, b_reg;
    logic [CW-1:0]    cnt_reg;
    logic [1:0]       kind_reg;
    logic [WIDTH-1:0] acc_next, a_next, b_next;
    logic [WIDTH:0]   rem_sh;

    always_comb begin
        acc_next = acc_reg;
        a_next   = a_reg;
        b_next   = b_reg;
        rem_sh   = {acc_reg, a_reg[WIDTH-1]};
        if (kind_reg == 2'b00) begin
            acc_next = acc_reg + (a_reg[0] ? b_reg : '0);
            a_next   = a_reg >> 1;
            b_next   = b_reg << 1;
        end else if (rem_sh >= {1'b0, b_reg}) begin
            // A zero divisor always takes this branch. That gives a quotient of
            // all ones and a remainder equal to the dividend, with no special case.
            acc_next = WIDTH'(rem_sh - {1'b0, b_reg});
            a_next   = {a_reg[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = rem_sh[WIDTH-1:0];
            a_next   = {a_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_reg  <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            cnt_reg  <= '0;
            kind_reg <= 2'b00;
        end else if (accept && is_iter) begin
            kind_reg <= op[1:0];
            acc_reg  <= '0;
            cnt_reg  <= '0;
            a_reg    <= (op == OP_MUL) ? y : x;
            b_reg    <= (op == OP_MUL) ? x : y;
        end else if ((state_reg == CALC) && (cnt_reg != LAST)) begin
            acc_reg <= acc_next;
            a_reg   <= a_next;
            b_reg   <= b_next;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // WIDTH iteration cycles. The cycle after the last one moves the FSM to DONE.
    assign calc_done   = (state_reg == CALC) && (cnt_reg == LAST);
    assign calc_result = (kind_reg == 2'b01) ? a_reg : acc_reg;
`else
    assign calc_done   = 1'b0;
    assign calc_result = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            r_reg       <= '0;
            zero_reg    <= 1'b0;
            neg_reg     <= 1'b0;
            carry_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (accept) begin
            if (is_iter) begin
                state_reg <= CALC;
            end else begin
                state_reg   <= DONE;
                r_reg       <= quick_r;
                zero_reg    <= (quick_r == '0);
                neg_reg     <= quick_r[WIDTH-1];
                carry_reg   <= quick_carry;
                ovf_reg     <= quick_ovf;
                illegal_reg <= quick_illegal;
            end
        end else if ((state_reg == CALC) && calc_done) begin
            state_reg   <= DONE;
            r_reg       <= calc_result;
            zero_reg    <= (calc_result == '0);
            neg_reg     <= calc_result[WIDTH-1];
            carry_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            illegal_reg <= 1'b0;
        end else if ((state_reg == DONE) && out_ready) begin
            state_reg <= IDLE;
        end else if (state_reg == 2'd3) begin
            state_reg <= IDLE;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
//
// Directed bench for alu_multicycle with WIDTH = 32. The main initial block
// issues operations and pushes the expected result onto a scoreboard queue. A
// negedge monitor pops and compares each result that the consumer takes.
// MUL/DIVU/REMU expectations follow the ALU_MULDIV_EN macro.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] r;
        logic         zero;
        logic         neg;
        logic         carry;
        logic         ovf;
        logic         illegal;
    } exp_t;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x, y;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         zero, neg, carry, ovf, illegal;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    alu_multicycle #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .zero      (zero),
        .neg       (neg),
        .carry     (carry),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] s;
        e    = '0;
        e.op = o;
        case (o)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0011: e.r = a ^ b;
            4'b0100: e.r = a << b[4:0];
            4'b0101: e.r = a >> b[4:0];
            4'b0010: begin
                s       = {1'b0, a} + {1'b0, b};
                e.r     = s[W-1:0];
                e.carry = s[W];
                e.ovf   = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            4'b0110: begin
                e.r     = a - b;
                e.carry = (a >= b);
                e.ovf   = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            4'b0111: e.r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'b1000: if (MULDIV) e.r = a * b; else e.illegal = 1'b1;
            4'b1001: if (MULDIV) e.r = (b == 0) ? '1 : a / b; else e.illegal = 1'b1;
            4'b1010: if (MULDIV) e.r = (b == 0) ? a : a % b; else e.illegal = 1'b1;
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.r == 0);
        e.neg  = e.r[W-1];
        return e;
    endfunction

    function automatic int exp_lat(input logic [3:0] o);
        return (MULDIV && (o >= 4'b1000) && (o <= 4'b1010)) ? W + 1 : 1;
    endfunction

    // Presents an operation and returns at accept edge + 1.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        sb.push_back(model(o, a, b));
        op       = o;
        x        = a;
        y        = b;
        in_valid = 1'b1;
        guard    = 0;
        @(negedge clock);
        while (!in_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        chk("accept_in_time", 64'(guard < 100), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges since accept until out_valid, bounded.
    task automatic wait_out(input int start, input int expect_lat, input string tag);
        int lat;
        lat = start;
        while (!out_valid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk(tag, 64'(lat), 64'(expect_lat));
    endtask

    // Scoreboard monitor: a result is consumed at the edge after this negedge.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            chk("output_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("r_op%0h", e.op), 64'(r), 64'(e.r));
                chk($sformatf("flags_op%0h", e.op),
                    64'({zero, neg, carry, ovf, illegal}),
                    64'({e.zero, e.neg, e.carry, e.ovf, e.illegal}));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vecs = '{
            '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001},
            '{4'b0110, 32'h8000_0000, 32'h0000_0001},
            '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00},
            '{4'b0001, 32'hF0F0_F0F0, 32'h0F00_000F},
            '{4'b0011, 32'h1234_5678, 32'hFFFF_0000},
            '{4'b0100, 32'h0000_0001, 32'd31},
            '{4'b0100, 32'h0000_0003, 32'd36},
            '{4'b0101, 32'h8000_0000, 32'd4},
            '{4'b0110, 32'd5, 32'd5},
            '{4'b0111, 32'd5, 32'd5},
            '{4'b0111, 32'hFFFF_FFFF, 32'd1},
            '{4'b0111, 32'd1, 32'hFFFF_FFFF},
            '{4'b0010, 32'h7FFF_FFFF, 32'd1},
            '{4'b0110, 32'd3, 32'd5},
            '{4'b1111, 32'd9, 32'd9},
            '{4'b1011, 32'd1, 32'd2},
            '{4'b1000, 32'd1234, 32'd5678},
            '{4'b1001, 32'd100, 32'd7},
            '{4'b1010, 32'd100, 32'd7},
            '{4'b1001, 32'd55, 32'd0},
            '{4'b1010, 32'd55, 32'd0}
        };

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        x         = '0;
        y         = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_r", 64'(r), 64'd0);
        chk("rst_flags", 64'({zero, neg, carry, ovf, illegal}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_out(1, exp_lat(vecs[i].op), $sformatf("latency_op%0h", vecs[i].op));
            if (i == 0) begin
                chk("add_wrap_r", 64'(r), 64'd0);
                chk("add_wrap_zc", 64'({zero, carry, ovf}), 64'b110);
            end
        end

        // Literal checks for the illegal opcode.
        issue(4'b1111, 32'hDEAD_BEEF, 32'h1);
        wait_out(1, 1, "latency_illegal");
        chk("illegal_flag", 64'(illegal), 64'd1);
        chk("illegal_r", 64'(r), 64'd0);

`ifdef ALU_MULDIV_EN
        // in_valid during CALC must be ignored and the operands must not be sampled.
        issue(4'b1000, 32'd1234, 32'd5678);
        op       = 4'b0010;
        x        = 32'd5;
        y        = 32'd5;
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk("calc_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        wait_out(6, W + 1, "latency_mul_busy");
        chk("mul_r", 64'(r), 64'd7006652);
`endif

        // Hold the result while the consumer stalls, then issue back-to-back.
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        issue(4'b0010, 32'd10, 32'd20);
        wait_out(1, 1, "latency_hold_add");
        for (int k = 0; k < 5; k++) begin
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_r", 64'(r), 64'd30);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        issue(4'b0011, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
        chk("no_bubble_out_valid", 64'(out_valid), 64'd1);
        chk("no_bubble_r", 64'(r), 64'hAAAA_AAAA);
        @(posedge clock);
        #1;

        // Reset takes priority over a simultaneous accept.
        op       = 4'b0010;
        x        = 32'd1;
        y        = 32'd2;
        in_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_prio_out_valid", 64'(out_valid), 64'd0);
        chk("rst_prio_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        chk("rst_prio_no_late_valid", 64'(out_valid), 64'd0);

`ifdef ALU_MULDIV_EN
        // Reset in the middle of a divide aborts it without producing a result.
        issue(4'b1001, 32'd100, 32'd7);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        void'(sb.pop_back());
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_r", 64'(r), 64'd0);
        repeat (40) @(posedge clock);
        #1;
        chk("abort_no_result", 64'(out_valid), 64'd0);
`endif

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
